// File: rtl/text_vga_pkg.sv
// Shared constants and pipeline stage record for the text-mode VGA pixel path.
package text_vga_pkg;

    localparam int unsigned COLS     = 80;
    localparam int unsigned ROWS     = 30;
    localparam int unsigned CHAR_W   = 8;
    localparam int unsigned CHAR_H   = 16;
    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;

    localparam int unsigned COL_W       = 7;
    localparam int unsigned ROW_W       = 5;
    localparam int unsigned GLYPH_ROW_W = 4;
    localparam int unsigned BIT_IDX_W   = 3;

    localparam int unsigned BLINK_FRAMES_DFLT = 30;

    typedef struct packed {
        logic [COL_W-1:0]       col;
        logic [ROW_W-1:0]       row;
        logic [GLYPH_ROW_W-1:0] glyph_row;
        logic [BIT_IDX_W-1:0]   bit_idx;
        logic                   video_on;
        logic                   hsync;
        logic                   vsync;
    } pix_stage_t;

    // Syncs are active-low, so an idle stage carries them high.
    localparam pix_stage_t STAGE_RST = '{
        col:       '0,
        row:       '0,
        glyph_row: '0,
        bit_idx:   '0,
        video_on:  1'b0,
        hsync:     1'b1,
        vsync:     1'b1
    };

endpackage

// File: rtl/cursor_blink_timer.sv
// Counts vsync falling edges and toggles cursor visibility every BLINK_FRAMES frames.
module cursor_blink_timer
    import text_vga_pkg::*;
#(
    parameter int unsigned BLINK_FRAMES = BLINK_FRAMES_DFLT
) (
    input  logic clk,
    input  logic reset,
    input  logic vsync_in,
    output logic cursor_vis
);

    localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    logic             vs_prev_d, vs_prev_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             vis_d, vis_q;

    always_comb begin
        vs_prev_d = vsync_in;
        cnt_d     = cnt_q;
        vis_d     = vis_q;
        if (vs_prev_q && !vsync_in) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                vis_d = ~vis_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vs_prev_q <= 1'b1;
            cnt_q     <= '0;
            vis_q     <= 1'b1;
        end else begin
            vs_prev_q <= vs_prev_d;
            cnt_q     <= cnt_d;
            vis_q     <= vis_d;
        end
    end

    assign cursor_vis = vis_q;

endmodule

// File: rtl/text_pixel_pipeline.sv
// Three-stage text buffer fetch, glyph bit select, cursor overlay and sync delay.
// Cursor blinking is enabled by defining TEXT_CURSOR_BLINK_EN.
module text_pixel_pipeline
    import text_vga_pkg::*;
`ifdef TEXT_CURSOR_BLINK_EN
#(
    parameter int unsigned BLINK_FRAMES = BLINK_FRAMES_DFLT
)
`endif
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [9:0]             h_pos,
    input  logic [9:0]             v_pos,
    input  logic                   video_on,
    input  logic                   hsync_in,
    input  logic                   vsync_in,
    output logic [COL_W-1:0]       buf_col,
    output logic [ROW_W-1:0]       buf_row,
    input  logic [7:0]             buf_char,
    output logic [7:0]             rom_code,
    output logic [GLYPH_ROW_W-1:0] rom_row,
    input  logic [7:0]             rom_pixels,
    input  logic [COL_W-1:0]       cursor_x,
    input  logic [ROW_W-1:0]       cursor_y,
    output logic                   pixel_out,
    output logic                   hsync,
    output logic                   vsync
);

    localparam logic [COL_W-1:0] COLS_L = COL_W'(COLS);
    localparam logic [ROW_W-1:0] ROWS_L = ROW_W'(ROWS);

    pix_stage_t s1_d, s1_q;
    pix_stage_t s2_d, s2_q;
    logic       cur_hit_d, cur_hit_q;
    logic       pixel_d, pixel_q;
    logic       hsync_d, hsync_q;
    logic       vsync_d, vsync_q;
    logic       cursor_vis;
    logic       unused_v_msb;

    assign unused_v_msb = v_pos[9];

`ifdef TEXT_CURSOR_BLINK_EN
    cursor_blink_timer #(
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_blink (
        .clk        (clk),
        .reset      (reset),
        .vsync_in   (vsync_in),
        .cursor_vis (cursor_vis)
    );
`else
    assign cursor_vis = 1'b1;
`endif

    always_comb begin
        s1_d           = STAGE_RST;
        s1_d.glyph_row = v_pos[3:0];
        s1_d.bit_idx   = h_pos[2:0];
        s1_d.video_on  = video_on;
        s1_d.hsync     = hsync_in;
        s1_d.vsync     = vsync_in;
        if (video_on) begin
            s1_d.col = h_pos[9:3];
            s1_d.row = v_pos[8:4];
        end

        s2_d = s1_q;

        // Hit is evaluated on the cell entering S2 and registered alongside it,
        // so the cursor inputs are sampled exactly at the S2 capture edge.
        cur_hit_d = cursor_vis
                 && (cursor_x < COLS_L) && (cursor_y < ROWS_L)
                 && (s1_q.col == cursor_x) && (s1_q.row == cursor_y);

        pixel_d = s2_q.video_on & (rom_pixels[3'd7 - s2_q.bit_idx] ^ cur_hit_q);
        hsync_d = s2_q.hsync;
        vsync_d = s2_q.vsync;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q      <= STAGE_RST;
            s2_q      <= STAGE_RST;
            cur_hit_q <= 1'b0;
            pixel_q   <= 1'b0;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            cur_hit_q <= cur_hit_d;
            pixel_q   <= pixel_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
        end
    end

    assign buf_col   = s1_q.col;
    assign buf_row   = s1_q.row;
    assign rom_code  = buf_char;
    assign rom_row   = s2_q.glyph_row;
    assign pixel_out = pixel_q;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;

endmodule

// File: tb/tb_text_pixel_pipeline.sv
// Directed bench for text_pixel_pipeline: streamed vector table plus reset, sync, cursor and blink sequences.
module tb_text_pixel_pipeline;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] h_pos, v_pos;
    logic       video_on, hsync_in, vsync_in;
    logic [6:0] buf_col;
    logic [4:0] buf_row;
    logic [7:0] buf_char, rom_code;
    logic [3:0] rom_row;
    logic [7:0] rom_pixels;
    logic [6:0] cursor_x;
    logic [4:0] cursor_y;
    logic       pixel_out, hsync, vsync;

    always #5 clk = ~clk;

`ifdef TEXT_CURSOR_BLINK_EN
    text_pixel_pipeline #(.BLINK_FRAMES(2)) dut (
`else
    text_pixel_pipeline dut (
`endif
        .clk(clk), .reset(reset), .h_pos(h_pos), .v_pos(v_pos), .video_on(video_on),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .buf_col(buf_col), .buf_row(buf_row),
        .buf_char(buf_char), .rom_code(rom_code), .rom_row(rom_row), .rom_pixels(rom_pixels),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .pixel_out(pixel_out), .hsync(hsync), .vsync(vsync)
    );

    typedef struct {
        int h, v, von, hs, vs, rom, cx, cy;
        int pix, col, row, gr;
    } vec_t;

    localparam int N = 16;
    vec_t vecs[N];
    int   tests = 0;
    int   fails = 0;
    bit   exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input int h, input int v, input int von, input int hs, input int vs);
        h_pos    = 10'(h);
        v_pos    = 10'(v);
        video_on = 1'(von);
        hsync_in = 1'(hs);
        vsync_in = 1'(vs);
    endtask

    task automatic reset_pulse();
        drive(0, 0, 0, 1, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    // Streams one pixel per clock; checks the pixel launched two calls earlier.
    task automatic stream_px(input string name, input int h, input int v, input int von,
                             input int vs, input bit ex);
        drive(h, v, von, 1, vs);
        exp_q.push_back(ex);
        @(posedge clk); #1;
        if (exp_q.size() >= 3) chk(name, 32'(pixel_out), 32'(exp_q.pop_front()));
    endtask

    function automatic bit blink_vis(input int f);
`ifdef TEXT_CURSOR_BLINK_EN
        return (f < 2) || (f >= 4);
`else
        return (f >= 0);
`endif
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          h    v    von hs vs rom    cx  cy   pix col row gr
        vecs[0]  = '{8,   16,  1,  1, 1, 'h80, 80, 0,   1,  1,  1,  0};
        vecs[1]  = '{9,   16,  1,  1, 1, 'h80, 80, 0,   0,  1,  1,  0};
        vecs[2]  = '{15,  17,  1,  1, 1, 'h01, 80, 0,   1,  1,  1,  1};
        vecs[3]  = '{16,  31,  1,  1, 1, 'h01, 80, 0,   0,  2,  1,  15};
        vecs[4]  = '{8,   16,  1,  1, 1, 'h00, 1,  1,   1,  1,  1,  0};
        vecs[5]  = '{15,  31,  1,  1, 1, 'h00, 1,  1,   1,  1,  1,  15};
        vecs[6]  = '{16,  16,  1,  1, 1, 'h00, 1,  1,   0,  2,  1,  0};
        vecs[7]  = '{8,   32,  1,  1, 1, 'h00, 1,  1,   0,  1,  2,  0};
        vecs[8]  = '{10,  20,  1,  1, 1, 'hFF, 1,  1,   0,  1,  1,  4};
        vecs[9]  = '{640, 20,  0,  1, 1, 'hFF, 1,  1,   0,  0,  0,  4};
        vecs[10] = '{700, 490, 0,  0, 1, 'hFF, 80, 0,   0,  0,  0,  10};
        vecs[11] = '{639, 479, 1,  1, 1, 'h01, 80, 0,   1,  79, 29, 15};
        vecs[12] = '{639, 479, 1,  1, 1, 'h01, 79, 29,  0,  79, 29, 15};
        vecs[13] = '{0,   0,   1,  1, 1, 'h80, 80, 30,  1,  0,  0,  0};
        vecs[14] = '{0,   0,   1,  1, 1, 'h80, 0,  30,  1,  0,  0,  0};
        vecs[15] = '{5,   3,   1,  1, 0, 'h04, 0,  0,   0,  0,  0,  3};

        reset      = 1'b0;
        drive(0, 0, 0, 1, 1);
        buf_char   = 8'h00;
        rom_pixels = 8'h00;
        cursor_x   = 7'd80;
        cursor_y   = 5'd0;
        @(posedge clk);
        @(posedge clk); #1;
        chk("rst_pixel", 32'(pixel_out), 0);
        chk("rst_hsync", 32'(hsync), 1);
        chk("rst_vsync", 32'(vsync), 1);
        chk("rst_buf_col", 32'(buf_col), 0);
        chk("rst_buf_row", 32'(buf_row), 0);
        chk("rst_rom_row", 32'(rom_row), 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        // Streamed table: ROM data lags two cycles, cursor one cycle, behind the beam.
        for (int i = 0; i < N + 2; i++) begin
            if (i < N) drive(vecs[i].h, vecs[i].v, vecs[i].von, vecs[i].hs, vecs[i].vs);
            else       drive(0, 0, 0, 1, 1);
            if (i >= 2) rom_pixels = 8'(vecs[i-2].rom);
            else        rom_pixels = 8'h00;
            if (i >= 1 && i <= N) begin
                cursor_x = 7'(vecs[i-1].cx);
                cursor_y = 5'(vecs[i-1].cy);
            end else begin
                cursor_x = 7'd80;
                cursor_y = 5'd0;
            end
            buf_char = 8'(32'h30 + i);
            @(posedge clk); #1;
            chk("rom_code", 32'(rom_code), 32'h30 + i);
            if (i < N) begin
                chk("buf_col", 32'(buf_col), vecs[i].col);
                chk("buf_row", 32'(buf_row), vecs[i].row);
            end
            if (i >= 1 && i <= N) chk("rom_row", 32'(rom_row), vecs[i-1].gr);
            if (i >= 2) begin
                chk("tbl_pixel", 32'(pixel_out), vecs[i-2].pix);
                chk("tbl_hsync", 32'(hsync), vecs[i-2].hs);
                chk("tbl_vsync", 32'(vsync), vecs[i-2].vs);
            end
        end

        // Mid-frame reset with an active pattern, then 3-edge recovery.
        drive(8, 16, 1, 0, 0);
        rom_pixels = 8'hFF;
        cursor_x   = 7'd80;
        cursor_y   = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_pixel", 32'(pixel_out), 1);
        chk("pre_rst_hsync", 32'(hsync), 0);
        chk("pre_rst_buf_col", 32'(buf_col), 1);
        #2 reset = 1'b0;
        #1;
        chk("midrst_pixel", 32'(pixel_out), 0);
        chk("midrst_hsync", 32'(hsync), 1);
        chk("midrst_vsync", 32'(vsync), 1);
        chk("midrst_buf_col", 32'(buf_col), 0);
        chk("midrst_buf_row", 32'(buf_row), 0);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            chk("rel_pixel", 32'(pixel_out), (k == 3) ? 1 : 0);
            chk("rel_hsync", 32'(hsync), (k == 3) ? 0 : 1);
            chk("rel_vsync", 32'(vsync), (k == 3) ? 0 : 1);
        end

        // Sync alignment: hsync_in falls after edge N, vsync_in after edge N+2.
        drive(0, 0, 0, 1, 1);
        repeat (3) @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 1);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            chk("align_hsync", 32'(hsync), (k >= 3) ? 0 : 1);
            chk("align_vsync", 32'(vsync), (k >= 5) ? 0 : 1);
            if (k == 2) drive(0, 0, 0, 0, 0);
        end

        // Blanking: ROM all ones must never reach the output.
        drive(640, 100, 0, 1, 1);
        rom_pixels = 8'hFF;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            chk("blank_buf_col", 32'(buf_col), 0);
            if (k >= 3) chk("blank_pixel", 32'(pixel_out), 0);
        end

        // Full-cell cursor invert over blank glyphs; neighbour cell stays dark.
        reset_pulse();
        rom_pixels = 8'h00;
        cursor_x   = 7'd1;
        cursor_y   = 5'd1;
        exp_q.delete();
        for (int v = 16; v < 32; v++)
            for (int h = 8; h < 24; h++)
                stream_px("cursor_cell", h, v, 1, 1, (h < 16));
        stream_px("cursor_flush", 0, 0, 0, 1, 1'b0);
        stream_px("cursor_flush", 0, 0, 0, 1, 1'b0);

        cursor_x = 7'd80;
        exp_q.delete();
        for (int v = 16; v < 32; v++)
            for (int h = 8; h < 16; h++)
                stream_px("cursor_offscreen", h, v, 1, 1, 1'b0);
        stream_px("cursor_flush", 0, 0, 0, 1, 1'b0);
        stream_px("cursor_flush", 0, 0, 0, 1, 1'b0);

        // Blink: five frames separated by vsync pulses, counter fresh from reset.
        reset_pulse();
        cursor_x = 7'd1;
        cursor_y = 5'd1;
        for (int f = 0; f < 5; f++) begin
            exp_q.delete();
            for (int h = 8; h < 16; h++)
                stream_px("blink_frame", h, 16, 1, 1, blink_vis(f));
            stream_px("blink_flush", 0, 0, 0, 1, 1'b0);
            stream_px("blink_flush", 0, 0, 0, 1, 1'b0);
            stream_px("blink_vs", 0, 0, 0, 0, 1'b0);
            stream_px("blink_vs", 0, 0, 0, 0, 1'b0);
            stream_px("blink_vs", 0, 0, 0, 1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/text_pixel_pipeline.md
Name: text_pixel_pipeline

Overview:
- Fixed-latency pixel fetch/serialise pipeline between `vga_sync` and the VGA output pins.
- Takes beam position and raw syncs from `vga_sync` and drives the `text_buffer` read address.
- Forwards the returned character code and glyph row to `ascii_rom`, then selects one glyph bit per pixel clock.
- Overlays the text cursor and delays hsync/vsync so they stay aligned with `pixel_out`.

Parameters:
- COLS, 80, text columns
- ROWS, 30, text rows
- CHAR_W, 8, glyph width in pixels (fixed power of two)
- CHAR_H, 16, glyph height in pixels (fixed power of two)
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- BLINK_FRAMES, 30, frames per cursor blink half-period (used only with the optional feature)

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-low reset
- h_pos  in  10  beam x from `vga_sync`
- v_pos  in  10  beam y from `vga_sync`
- video_on  in  1  visible-area flag from `vga_sync`
- hsync_in  in  1  raw hsync, active-low
- vsync_in  in  1  raw vsync, active-low
- buf_col  out  7  text buffer read column (registered)
- buf_row  out  5  text buffer read row (registered)
- buf_char  in  8  text buffer read data; synchronous read, valid one cycle after address
- rom_code  out  8  ASCII ROM code (= buf_char, wire)
- rom_row  out  4  ASCII ROM glyph row (registered)
- rom_pixels  in  8  ASCII ROM row data; combinational; MSB = leftmost pixel
- cursor_x  in  7  cursor column
- cursor_y  in  5  cursor row
- pixel_out  out  1  monochrome pixel (registered)
- hsync  out  1  aligned hsync
- vsync  out  1  aligned vsync

Behaviour:
- Three stages; latency is exactly 3 clk edges from h_pos/v_pos/video_on/syncs sampled to pixel_out/hsync/vsync.
- E1 (S1 capture):
  - buf_col <= h_pos[9:3]; buf_row <= v_pos[8:4].
  - S1 also holds glyph_row=v_pos[3:0], bit_idx=h_pos[2:0], video_on, hsync_in, vsync_in.
  - When video_on=0, buf_col and buf_row load 0 so no out-of-range buffer read is issued.
- E2 (S2 capture):
  - S2 <= S1 metadata plus col/row.
  - rom_row = S2.glyph_row; rom_code = buf_char, which is now valid for the S1 address.
  - cur_hit = (S2.col==cursor_x) && (S2.row==cursor_y) && cursor_vis.
- E3 (output):
  - pixel_out <= S2.video_on & (rom_pixels[7-S2.bit_idx] ^ cur_hit).
  - hsync <= S2.hsync; vsync <= S2.vsync.
- Cursor:
  - Rendered as a full-cell invert (8x16).
  - cursor_x>=COLS or cursor_y>=ROWS is never drawn.
  - Cursor inputs are sampled at E2 with no extra delay; a cursor move mid-frame takes effect on the next cell processed.
- Reset:
  - Asserting reset clears all stage registers asynchronously.
  - Reset values: pixel_out=0, buf_col=0, buf_row=0, rom_row=0, hsync=1, vsync=1.
  - Reset mid-frame produces no glitch beyond those values.
  - First valid output appears on the 3rd edge after reset release.
- Without the optional feature, cursor_vis=1 permanently.
- Blanking and retrace regions output 0 regardless of buffer or ROM data.

Optional Feature:
- Macro: TEXT_CURSOR_BLINK_EN.
- Defined:
  - A frame counter increments on each falling edge of vsync_in, detected with a registered previous value.
  - At BLINK_FRAMES it wraps to 0 and toggles cursor_vis.
  - cursor_vis resets to 1 and the counter resets to 0.
- Undefined:
  - No counter logic; cursor_vis is constant 1 (steady cursor).

Decomposition:
- Package `text_vga_pkg` holds:
  - COLS, ROWS, CHAR_W, CHAR_H, H_ACTIVE, V_ACTIVE.
  - Derived widths: COL_W=7, ROW_W=5, GLYPH_ROW_W=4, BIT_IDX_W=3.
  - Typedef `pix_stage_t` {col, row, glyph_row, bit_idx, video_on, hsync, vsync}, used for S1 and S2.
- Sub-module `cursor_blink_timer` (clk, reset, vsync_in -> cursor_vis), instantiated only under TEXT_CURSOR_BLINK_EN.

Test Plan:
- Reset: drive reset=0 mid-line with an active pattern -> immediately pixel_out=0, hsync=1, vsync=1, buf_col=0, buf_row=0. Release -> first valid pixel on the 3rd edge.
- Fetch/latency: h_pos=8, v_pos=16, video_on=1 -> after E1 buf_col=1, buf_row=1. Return buf_char=0x41 and rom_pixels=0x80 -> rom_code=0x41, rom_row=0; pixel_out=1 at E3 for h_pos=8 and 0 for h_pos=9..15.
- Sync alignment: hsync_in falls at edge N, vsync_in falls at edge M -> hsync falls at N+3, vsync falls at M+3, each exactly.
- Blanking: h_pos=640, video_on=0, rom_pixels=0xFF -> pixel_out=0 and buf_col=0 throughout.
- Cursor: cursor_x=1, cursor_y=1, rom_pixels=0x00 -> pixel_out=1 for all 128 pixels of cell (1,1) and 0 in cell (2,1). With cursor_x=80 -> no invert anywhere.
- Blink (TEXT_CURSOR_BLINK_EN, BLINK_FRAMES=2) -> cursor visible in frames 0-1, hidden in frames 2-3, visible again in frame 4. Macro undefined -> cursor visible in all frames.
